pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder; successor to the single-bit combinational full adder in the SISD datapath. Splits a WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages. Operand skew and result deskew are handled internally. Valid/ready handshake on both sides lets the ALU stall it.

---
 rtl/flynn_arith_pkg.sv | 13 +
 rtl/adder_chunk.sv | 38 +++
 rtl/pipelined_adder.sv | 118 +++++++++++
 tb/tb_pipelined_adder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/flynn_arith_pkg.sv
// Shared helpers for the pipelined arithmetic blocks: configuration legality
// check and chunk-width derivation used by pipelined_adder.
package flynn_arith_pkg;

    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Stateless CHUNK-bit ripple-carry adder built from full_adder cells; one
// instance per pipeline stage of pipelined_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[W];
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES ripple chunks with a registered carry per
// stage and valid/ready flow control. Define PIPELINED_ADDER_OVERFLOW_EN to add o_overflow.
module pipelined_adder
    import flynn_arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_valid,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    output logic             o_overflow,
`endif
    input  logic             i_ready
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             cy_p  [STAGES];
    logic             vld_p [STAGES];

    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic             cin    [STAGES];
    logic             vld_in [STAGES];
    logic [CHUNK-1:0] s_k    [STAGES];
    logic             co_k   [STAGES];

    assign adv     = !vld_p[STAGES-1] || i_ready;
    assign o_ready = adv;

    // Operands shift down one chunk per stage (skew); finished sum chunks enter
    // from the top and shift down so the full sum is aligned at the last stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Bubbles are zeroed on entry so idle output data reads as zero.
            assign a_in[k]   = i_valid ? i_a : '0;
            assign b_in[k]   = i_valid ? i_b : '0;
            assign sum_in[k] = '0;
            assign cin[k]    = i_valid & i_carry;
            assign vld_in[k] = i_valid;
        end else begin : g_body
            assign a_in[k]   = a_p[k-1];
            assign b_in[k]   = b_p[k-1];
            assign sum_in[k] = sum_p[k-1];
            assign cin[k]    = cy_p[k-1];
            assign vld_in[k] = vld_p[k-1];
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a   (a_in[k][CHUNK-1:0]),
            .b   (b_in[k][CHUNK-1:0]),
            .cin (cin[k]),
            .sum (s_k[k]),
            .cout(co_k[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                sum_p[k] <= '0;
                cy_p[k]  <= 1'b0;
                vld_p[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= a_in[k] >> CHUNK;
                b_p[k]   <= b_in[k] >> CHUNK;
                sum_p[k] <= (sum_in[k] >> CHUNK) | (WIDTH'(s_k[k]) << (WIDTH - CHUNK));
                cy_p[k]  <= co_k[k];
                vld_p[k] <= vld_in[k];
            end
        end
    end

    assign o_sum   = sum_p[STAGES-1];
    assign o_carry = cy_p[STAGES-1];
    assign o_valid = vld_p[STAGES-1];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic ov_in;
    logic ov_p;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign ov_in = a_in[STAGES-1][CHUNK-1] ^ b_in[STAGES-1][CHUNK-1]
                 ^ s_k[STAGES-1][CHUNK-1] ^ co_k[STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_p <= 1'b0;
        end else if (adv) begin
            ov_p <= ov_in;
        end
    end

    assign o_overflow = ov_p;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: scoreboard on a 32/4 instance plus
// directed checks on 8/2 and 16/1 instances.
module tb_pipelined_adder;
    localparam int S32 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        c32 = 1'b0, v32 = 1'b0, rdy32 = 1'b1, ordy32, co32, vld32;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        c8 = 1'b0, v8 = 1'b0, rdy8 = 1'b1, ordy8, co8, vld8;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        c16 = 1'b0, v16 = 1'b0, rdy16 = 1'b1, ordy16, co16, vld16;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic ov32, ov8, ov16;
`endif

    pipelined_adder #(.WIDTH(32), .STAGES(S32)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a32), .i_b(b32), .i_carry(c32),
        .i_valid(v32), .o_ready(ordy32), .o_sum(sum32), .o_carry(co32),
        .o_valid(vld32),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        .o_overflow(ov32),
`endif
        .i_ready(rdy32)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a8), .i_b(b8), .i_carry(c8),
        .i_valid(v8), .o_ready(ordy8), .o_sum(sum8), .o_carry(co8),
        .o_valid(vld8),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        .o_overflow(ov8),
`endif
        .i_ready(rdy8)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a16), .i_b(b16), .i_carry(c16),
        .i_valid(v16), .o_ready(ordy16), .o_sum(sum16), .o_carry(co16),
        .o_valid(vld16),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        .o_overflow(ov16),
`endif
        .i_ready(rdy16)
    );

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        ov;
        int unsigned cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    bit   lat_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        exp_t e;
        logic [32:0] full;
        if (rst_n) begin
            if (vld32 && rdy32) begin
                if (q.size() == 0) begin
                    check("sb_spurious", 64'(vld32), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("sb_sum", 64'(sum32), 64'(e.sum));
                    check("sb_carry", 64'(co32), 64'(e.carry));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                    check("sb_ov", 64'(ov32), 64'(e.ov));
`endif
                    if (e.lat) check("sb_latency", 64'(cyc - e.cyc), 64'(S32));
                end
            end
            if (v32 && ordy32) begin
                full    = {1'b0, a32} + {1'b0, b32} + 33'(c32);
                e.sum   = full[31:0];
                e.carry = full[32];
                e.ov    = (a32[31] == b32[31]) && (full[31] != a32[31]);
                e.cyc   = cyc;
                e.lat   = lat_mode;
                q.push_back(e);
            end
        end
    end

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec);
        a8 = a; b8 = b; c8 = c; v8 = 1'b1;
        step();
        v8 = 1'b0;
        check({tag, "_v_early"}, 64'(vld8), 64'(0));
        step();
        check({tag, "_valid"}, 64'(vld8), 64'(1));
        check({tag, "_sum"}, 64'(sum8), 64'(es));
        check({tag, "_carry"}, 64'(co8), 64'(ec));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        check({tag, "_ov"}, 64'(ov8), 64'((a[7] == b[7]) && (es[7] != a[7])));
`endif
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic c);
        a32 = a; b32 = b; c32 = c; v32 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(vld32), 64'(0));
        check("rst_sum", 64'(sum32), 64'(0));
        check("rst_carry", 64'(co32), 64'(0));
        check("rst_valid8", 64'(vld8), 64'(0));
        #2 rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(ordy32), 64'(1));
        step();

        run8("basic", 8'h3C, 8'h4A, 1'b0, 8'h86, 1'b0);
        run8("xchunk", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        run8("wrap", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

        a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0; v16 = 1'b1;
        step();
        a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b1;
        check("s1_valid", 64'(vld16), 64'(1));
        check("s1_sum", 64'(sum16), 64'(16'h0000));
        check("s1_carry", 64'(co16), 64'(1));
        step();
        v16 = 1'b0;
        check("s1b_sum", 64'(sum16), 64'(16'h5556));
        check("s1b_carry", 64'(co16), 64'(0));

        // Back-to-back stream; the last few beats will see the stall.
        rdy32 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            lat_mode = (i < 100 - S32);
            if (i == 0) drive32(32'hFFFF_FFFF, 32'h0, 1'b1);
            else drive32($urandom, $urandom, 1'($urandom_range(0, 1)));
            #1;
            check("stream_ready", 64'(ordy32), 64'(1));
            step();
        end
        lat_mode = 1'b0;

        rdy32 = 1'b0;
        drive32($urandom, $urandom, 1'b1);
        for (int j = 0; j < 5; j++) begin
            #1;
            check("stall_ready", 64'(ordy32), 64'(0));
            check("stall_valid", 64'(vld32), 64'(1));
            check("stall_sum", 64'(sum32), (q.size() > 0) ? 64'(q[0].sum) : 64'hDEAD_BEEF_0000_0000);
            check("stall_carry", 64'(co32), (q.size() > 0) ? 64'(q[0].carry) : 64'h2);
            step();
        end
        rdy32 = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            drive32($urandom, $urandom, 1'($urandom_range(0, 1)));
            step();
        end
        v32 = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check("drain1", 64'(q.size()), 64'(0));

        for (int i = 0; i < S32; i++) begin
            drive32($urandom, $urandom, 1'($urandom_range(0, 1)));
            step();
        end
        v32 = 1'b0;
        #1;
        check("pre_rst_valid", 64'(vld32), 64'(1));
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_valid", 64'(vld32), 64'(0));
        check("mid_rst_sum", 64'(sum32), 64'(0));
        check("mid_rst_ready", 64'(ordy32), 64'(1));
        #12 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_valid", 64'(vld32), 64'(0));
        end
        drive32(32'h8000_0000, 32'h8000_0000, 1'b0);
        step();
        v32 = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check("drain2", 64'(q.size()), 64'(0));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
